fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction ROM.
- Owns the program counter, drives the ROM byte address and captures the returned word into the IF/ID pipeline register for the decoder.
- Handles sequential advance, branch/jump redirect, decode-requested stall and halt, and keeps a retired-fetch counter for bring-up.

Parameters:
ADDRESS_WIDTH, 32, width of PC and ROM address
DATA_WIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/boot

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous, active-high reset
imem_a  output  ADDRESS_WIDTH  byte address to instruction ROM (combinational = pc_f)
imem_rd  input  DATA_WIDTH  instruction word returned by ROM, same cycle
stall_i  input  1  decode hazard: hold PC and IF/ID
redirect_i  input  1  taken branch/jump from execute
target_i  input  ADDRESS_WIDTH  redirect byte address
halt_i  input  1  decode request to stop fetching
instr_d  output  DATA_WIDTH  IF/ID instruction
pc_d  output  ADDRESS_WIDTH  IF/ID PC of instr_d
pc_plus4_d  output  ADDRESS_WIDTH  IF/ID pc_d+4
valid_d  output  1  IF/ID entry valid
halted_o  output  1  stage is in HALTED
fetch_count_o  output  32  number of valid entries written to IF/ID
misalign_o  output  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
- State machine: BOOT, RUN, HALTED; registered state.
- Reset (rst=1 at a clock edge, in any state, including mid-stall or mid-redirect):
  - pc_f=RESET_PC, state=BOOT.
  - instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0.
  - fetch_count_o=0, misalign_o=0, halted_o=0.
- BOOT: one cycle only.
  - pc_f holds; IF/ID holds bubble.
  - All inputs are ignored. Next state is RUN.
- RUN: per-edge priority is redirect_i > halt_i > stall_i > advance.
  - redirect_i=1:
    - pc_f<=target_i.
    - IF/ID<=bubble (NOP_INSTR, valid_d=0); pc_d and pc_plus4_d hold their previous values.
    - Redirect wins over a simultaneous stall or halt.
  - halt_i=1 (no redirect):
    - IF/ID<=bubble; pc_f holds; state<=HALTED.
  - stall_i=1 (no redirect/halt): pc_f and the full IF/ID contents hold unchanged.
  - Otherwise (advance):
    - instr_d<=imem_rd, pc_d<=pc_f, pc_plus4_d<=pc_f+4.
    - valid_d<=1, pc_f<=pc_f+4, fetch_count_o<=fetch_count_o+1.
- HALTED: all registers hold; halted_o=1; only rst leaves HALTED.
- Arithmetic:
  - pc_f+4 is modulo 2^ADDRESS_WIDTH, so 32'hFFFF_FFFC advances to 32'h0.
  - fetch_count_o wraps from 32'hFFFF_FFFF to 0.
- Latency: word at address A appears on instr_d one edge after pc_f==A in an advance cycle.
- imem_a is purely combinational from pc_f; no ROM-side handshake (ROM is asynchronous read).
- halted_o is decoded from state, not separately registered.

Optional Feature:
Macro FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with target_i[1:0]!=2'b00 does not load pc_f; pc_f holds.
  - IF/ID is still bubbled.
  - misalign_o sets to 1 and stays set until rst.
  - Aligned redirects behave normally.
- Undefined:
  - target_i is loaded unmodified.
  - misalign_o is tied to 0.
  - No extra registers are built.

Test Plan:
- Reset then free-run, ROM words 0x00500093, 0x00100113, ... → after BOOT cycle, instr_d/pc_d pairs (0x00500093,0x0),(0x00100113,0x4) on consecutive edges; fetch_count_o=2.
- stall_i high 3 cycles at pc_f=0x8 → instr_d, pc_d, valid_d and imem_a frozen for 3 edges, then resume with pc_d=0x8; fetch_count_o unchanged during stall.
- redirect_i with target_i=0x40 while stall_i=1 → next edge pc_f=0x40, valid_d=0, instr_d=0x00000013; following edge pc_d=0x40, valid_d=1.
- halt_i at pc_f=0x10 → halted_o=1, valid_d=0, imem_a stuck at 0x10 for 10+ cycles; rst returns pc_f=RESET_PC, halted_o=0.
- Wrap: redirect to 0xFFFFFFFC, then advance → pc_d=0xFFFFFFFC, pc_plus4_d=0x0, imem_a=0x0.
- With FETCH_MISALIGN_CHECK_EN: redirect target_i=0x42 → pc_f unchanged, misalign_o=1 until rst. Without the macro: pc_f=0x42, misalign_o=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the async instruction ROM and fills IF/ID.
// Optional build macro FETCH_MISALIGN_CHECK_EN rejects redirects to non-word-aligned targets.
module fetch_stage #(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [DATA_WIDTH-1:0]  NOP_INSTR     = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] imem_a,
    input  logic [DATA_WIDTH-1:0]    imem_rd,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] target_i,
    input  logic                     halt_i,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic                     valid_d,
    output logic                     halted_o,
    output logic [31:0]              fetch_count_o,
    output logic                     misalign_o
);

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t                   state, state_next;
    logic [ADDRESS_WIDTH-1:0] pc_f;
    logic [ADDRESS_WIDTH-1:0] pc_f_plus4;
    logic                     target_bad;

    assign pc_f_plus4 = pc_f + ADDRESS_WIDTH'(4);
    assign imem_a     = pc_f;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    assign target_bad = (target_i[1:0] != 2'b00);
    assign misalign_o = misalign_q;

    always_ff @(posedge clk) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (state == RUN && redirect_i && target_bad)
            misalign_q <= 1'b1;
    end
`else
    assign target_bad = 1'b0;
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= BOOT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (!redirect_i && halt_i) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        halted_o = (state == HALTED);
    end

    // Only RUN touches the datapath; BOOT and HALTED simply hold everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f          <= RESET_PC;
            instr_d       <= NOP_INSTR;
            pc_d          <= '0;
            pc_plus4_d    <= '0;
            valid_d       <= 1'b0;
            fetch_count_o <= '0;
        end else if (state == RUN) begin
            if (redirect_i) begin
                if (!target_bad) pc_f <= target_i;
                instr_d <= NOP_INSTR;
                valid_d <= 1'b0;
            end else if (halt_i) begin
                instr_d <= NOP_INSTR;
                valid_d <= 1'b0;
            end else if (!stall_i) begin
                instr_d       <= imem_rd;
                pc_d          <= pc_f;
                pc_plus4_d    <= pc_f_plus4;
                valid_d       <= 1'b1;
                pc_f          <= pc_f_plus4;
                fetch_count_o <= fetch_count_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, advance, stall, redirect, halt, wrap, misaligned redirect.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        stall_i, redirect_i, halt_i;
    logic [31:0] target_i;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d, halted_o, misalign_o;
    logic [31:0] fetch_count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_a(imem_a), .imem_rd(imem_rd),
        .stall_i(stall_i), .redirect_i(redirect_i), .target_i(target_i), .halt_i(halt_i),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
        .halted_o(halted_o), .fetch_count_o(fetch_count_o), .misalign_o(misalign_o)
    );

    // ROM: two real instructions, everything else is 0x1000_0000 ^ address.
    always_comb begin
        case (imem_a)
            32'h0:   imem_rd = 32'h0050_0093;
            32'h4:   imem_rd = 32'h0010_0113;
            default: imem_rd = 32'h1000_0000 ^ imem_a;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0; target_i = '0;
        tick();
        chk("rst_imem_a", imem_a, 32'h0);
        chk("rst_instr", instr_d, 32'h13);
        chk("rst_pc_d", pc_d, 32'h0);
        chk("rst_pc4_d", pc_plus4_d, 32'h0);
        chk("rst_valid", {31'b0, valid_d}, 32'd0);
        chk("rst_count", fetch_count_o, 32'd0);
        chk("rst_halted", {31'b0, halted_o}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_o}, 32'd0);

        // BOOT edge: inputs ignored
        rst = 1'b0; redirect_i = 1'b1; target_i = 32'h100; halt_i = 1'b1;
        tick();
        chk("boot_imem_a", imem_a, 32'h0);
        chk("boot_valid", {31'b0, valid_d}, 32'd0);
        chk("boot_halted", {31'b0, halted_o}, 32'd0);
        redirect_i = 1'b0; halt_i = 1'b0;

        tick();
        chk("adv0_instr", instr_d, 32'h0050_0093);
        chk("adv0_pc_d", pc_d, 32'h0);
        chk("adv0_pc4_d", pc_plus4_d, 32'h4);
        chk("adv0_valid", {31'b0, valid_d}, 32'd1);
        chk("adv0_imem_a", imem_a, 32'h4);
        tick();
        chk("adv1_instr", instr_d, 32'h0010_0113);
        chk("adv1_pc_d", pc_d, 32'h4);
        chk("adv1_count", fetch_count_o, 32'd2);
        chk("adv1_imem_a", imem_a, 32'h8);

        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", instr_d, 32'h0010_0113);
            chk("stall_pc_d", pc_d, 32'h4);
            chk("stall_valid", {31'b0, valid_d}, 32'd1);
            chk("stall_imem_a", imem_a, 32'h8);
            chk("stall_count", fetch_count_o, 32'd2);
        end
        stall_i = 1'b0;
        tick();
        chk("resume_pc_d", pc_d, 32'h8);
        chk("resume_instr", instr_d, 32'h1000_0008);
        chk("resume_count", fetch_count_o, 32'd3);
        chk("resume_imem_a", imem_a, 32'hC);

        // redirect beats stall and halt
        stall_i = 1'b1; halt_i = 1'b1; redirect_i = 1'b1; target_i = 32'h40;
        tick();
        chk("redir_imem_a", imem_a, 32'h40);
        chk("redir_valid", {31'b0, valid_d}, 32'd0);
        chk("redir_instr", instr_d, 32'h13);
        chk("redir_pc_d_hold", pc_d, 32'h8);
        chk("redir_pc4_hold", pc_plus4_d, 32'hC);
        chk("redir_count", fetch_count_o, 32'd3);
        chk("redir_halted", {31'b0, halted_o}, 32'd0);
        stall_i = 1'b0; halt_i = 1'b0; redirect_i = 1'b0;
        tick();
        chk("post_redir_pc_d", pc_d, 32'h40);
        chk("post_redir_valid", {31'b0, valid_d}, 32'd1);
        chk("post_redir_instr", instr_d, 32'h1000_0040);
        chk("post_redir_count", fetch_count_o, 32'd4);

        redirect_i = 1'b1; target_i = 32'h10;
        tick();
        redirect_i = 1'b0;
        chk("to10_imem_a", imem_a, 32'h10);
        // halt beats stall
        halt_i = 1'b1; stall_i = 1'b1;
        tick();
        halt_i = 1'b0; stall_i = 1'b0;
        chk("halt_halted", {31'b0, halted_o}, 32'd1);
        chk("halt_valid", {31'b0, valid_d}, 32'd0);
        chk("halt_instr", instr_d, 32'h13);
        chk("halt_count", fetch_count_o, 32'd4);
        redirect_i = 1'b1; target_i = 32'h80;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halted_imem_a", imem_a, 32'h10);
            chk("halted_flag", {31'b0, halted_o}, 32'd1);
        end
        redirect_i = 1'b0;
        chk("halted_count", fetch_count_o, 32'd4);

        rst = 1'b1;
        tick();
        chk("rst2_imem_a", imem_a, 32'h0);
        chk("rst2_halted", {31'b0, halted_o}, 32'd0);
        chk("rst2_count", fetch_count_o, 32'd0);
        chk("rst2_pc_d", pc_d, 32'h0);

        // redirect held through BOOT only takes effect on the first RUN edge
        rst = 1'b0; redirect_i = 1'b1; target_i = 32'hFFFF_FFFC;
        tick();
        chk("boot2_imem_a", imem_a, 32'h0);
        tick();
        chk("wrap_redir_imem_a", imem_a, 32'hFFFF_FFFC);
        redirect_i = 1'b0;
        tick();
        chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
        chk("wrap_pc4_d", pc_plus4_d, 32'h0);
        chk("wrap_imem_a", imem_a, 32'h0);
        chk("wrap_instr", instr_d, 32'hEFFF_FFFC);
        chk("wrap_count", fetch_count_o, 32'd1);

        redirect_i = 1'b1; target_i = 32'h42;
        tick();
        redirect_i = 1'b0;
        chk("mis_valid", {31'b0, valid_d}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_imem_a", imem_a, 32'h0);
        chk("mis_flag", {31'b0, misalign_o}, 32'd1);
        tick();
        chk("mis_sticky", {31'b0, misalign_o}, 32'd1);
        chk("mis_adv_pc_d", pc_d, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mis_rst", {31'b0, misalign_o}, 32'd0);
`else
        chk("mis_imem_a", imem_a, 32'h42);
        chk("mis_flag", {31'b0, misalign_o}, 32'd0);
        tick();
        chk("mis_adv_pc_d", pc_d, 32'h42);
        chk("mis_adv_imem_a", imem_a, 32'h46);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
